// File: rtl/riot_io_timer.sv
// riot_io_timer: RIOT-style parallel I/O ports plus an 8-bit interval timer.
//
// Ports:
//   phi2          sole clock, all state updates on the rising edge
//   rst           asynchronous active-high reset
//   cs, we_n      chip select and write strobe (0=write, 1=read)
//   A[4:0]        register address
//   DI[7:0]       write data
//   DO[7:0]       read data, combinational, 8'h00 whenever OE=0
//   OE            cs & we_n
//   PI            pin inputs, port i at [8i+7:8i]
//   PO            output registers
//   PDIR          direction registers (1=output), drive pad output enables
//   irq           (tflag & tie) | (eflag & eie)
//
// Parameters: NPORTS (1..4) 8-bit ports; TIMER_RESET is the count at reset.
// Optional feature: define RIOT_EDGE_DETECT_EN to add edge detection on PI[7]
// with its own flag, enable and polarity. Without it eflag/eie read as 0.
//
// Bus protocol: there is no valid/ready handshake. A bus access is a
// single-cycle strobe: any cycle with cs=1 is one access, a write when
// we_n=0 and a read when we_n=1, and its side effects land on that
// cycle's rising edge of phi2. The device never stalls the bus.
module riot_io_timer #(
  parameter int         NPORTS      = 2,
  parameter logic [7:0] TIMER_RESET = 8'h00
) (
  input  logic                  phi2,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  we_n,
  input  logic [4:0]            A,
  input  logic [7:0]            DI,
  output logic [7:0]            DO,
  output logic                  OE,
  input  logic [8*NPORTS-1:0]   PI,
  output logic [8*NPORTS-1:0]   PO,
  output logic [8*NPORTS-1:0]   PDIR,
  output logic                  irq
);

  // Access strobes
  logic port_wr;
  logic timer_wr;
  logic timer_rd;

  assign OE       = cs & we_n;
  assign port_wr  = cs & ~we_n & ~A[4];
  assign timer_wr = cs & ~we_n & A[4] & ~A[2];
  assign timer_rd = cs & we_n & A[4] & ~A[2];

  // Timer state
  logic [7:0] count;
  logic [1:0] div_sel;
  logic [9:0] prescale;
  logic       tie;
  logic       tflag;
  logic       fast;      // after underflow the timer ticks every cycle
  logic       underflow;
  logic       eflag;
  logic       eie;

  // Prescaler reload value is divider-1.
  function automatic logic [9:0] div_reload(input logic [1:0] sel);
    case (sel)
      2'b00:   return 10'd0;
      2'b01:   return 10'd7;
      2'b10:   return 10'd63;
      default: return 10'd1023;
    endcase
  endfunction

  // Port registers; ports at or above NPORTS simply match no loop index.
  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      PO   <= '0;
      PDIR <= '0;
    end else if (port_wr) begin
      for (int i = 0; i < NPORTS; i++) begin
        if (A[3:1] == 3'(i)) begin
          if (A[0]) PDIR[8*i +: 8] <= DI;
          else      PO[8*i +: 8]   <= DI;
        end
      end
    end
  end

  assign underflow = (prescale == 10'd0) && (count == 8'h00);

  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      count    <= TIMER_RESET;
      div_sel  <= 2'b11;
      prescale <= 10'd1023;
      tie      <= 1'b0;
      tflag    <= 1'b0;
      fast     <= 1'b0;
    end else if (timer_wr) begin
      // A write beats a coincident underflow: flag stays clear.
      count    <= DI;
      div_sel  <= A[1:0];
      prescale <= div_reload(A[1:0]);
      tie      <= A[3];
      tflag    <= 1'b0;
      fast     <= 1'b0;
    end else begin
      if (prescale == 10'd0) begin
        count    <= count - 8'd1;
        prescale <= (fast || underflow) ? 10'd0 : div_reload(div_sel);
      end else begin
        prescale <= prescale - 10'd1;
      end
      if (underflow) fast <= 1'b1;
      if (timer_rd) tie <= A[3];
      // A read coincident with underflow leaves the flag set.
      if (underflow)     tflag <= 1'b1;
      else if (timer_rd) tflag <= 1'b0;
    end
  end

`ifdef RIOT_EDGE_DETECT_EN
  logic stat_rd;
  logic edge_wr;
  logic pa7_q;
  logic epol;
  logic eie_q;
  logic eflag_q;
  logic edge_hit;

  assign stat_rd  = cs & we_n & A[4] & A[2];
  assign edge_wr  = cs & ~we_n & A[4] & A[2];
  assign edge_hit = epol ? (~pa7_q & PI[7]) : (pa7_q & ~PI[7]);

  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      pa7_q   <= 1'b0;
      epol    <= 1'b0;
      eie_q   <= 1'b0;
      eflag_q <= 1'b0;
    end else begin
      pa7_q <= PI[7];
      if (edge_wr) begin
        epol  <= A[0];
        eie_q <= A[1];
      end
      // An edge coincident with a status read wins.
      if (edge_hit)     eflag_q <= 1'b1;
      else if (stat_rd) eflag_q <= 1'b0;
    end
  end

  assign eflag = eflag_q;
  assign eie   = eie_q;
`else
  assign eflag = 1'b0;
  assign eie   = 1'b0;
`endif

  assign irq = (tflag & tie) | (eflag & eie);

  // Read mux
  logic [7:0] port_rd;
  always_comb begin
    port_rd = 8'h00;
    for (int i = 0; i < NPORTS; i++) begin
      if (A[3:1] == 3'(i)) begin
        if (A[0]) port_rd = PDIR[8*i +: 8];
        else      port_rd = (PO[8*i +: 8] & PDIR[8*i +: 8]) |
                            (PI[8*i +: 8] & ~PDIR[8*i +: 8]);
      end
    end
  end

  always_comb begin
    DO = 8'h00;
    if (OE) begin
      if (!A[4])      DO = port_rd;
      else if (!A[2]) DO = count;
      else            DO = {tflag, eflag, 6'b0};
    end
  end

endmodule

// File: tb/tb_riot_io_timer.sv
// Testbench for riot_io_timer (NPORTS=2, TIMER_RESET=8'h00).
// Inputs change on the falling edge of phi2; combinational outputs are
// sampled 1 ns after that, registered results 1 ns after the rising edge.
module tb_riot_io_timer;

`ifdef RIOT_EDGE_DETECT_EN
  localparam logic EDGE_EN = 1'b1;
`else
  localparam logic EDGE_EN = 1'b0;
`endif

  logic        phi2;
  logic        rst;
  logic        cs;
  logic        we_n;
  logic [4:0]  A;
  logic [7:0]  DI;
  logic [7:0]  DO;
  logic        OE;
  logic [15:0] PI;
  logic [15:0] PO;
  logic [15:0] PDIR;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  riot_io_timer #(.NPORTS(2), .TIMER_RESET(8'h00)) dut (
    .phi2(phi2), .rst(rst), .cs(cs), .we_n(we_n), .A(A), .DI(DI),
    .DO(DO), .OE(OE), .PI(PI), .PO(PO), .PDIR(PDIR), .irq(irq)
  );

  // Clock
  initial phi2 = 1'b0;
  always #5 phi2 = ~phi2;

  typedef struct {
    logic        cs;
    logic        we_n;
    logic [4:0]  a;
    logic [7:0]  di;
    logic [15:0] pi;
    logic [7:0]  exp_do;
    logic        exp_oe;
    logic [15:0] exp_po;
    logic [15:0] exp_pdir;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic w, input logic [4:0] a, input logic [7:0] d);
    cs   = c;
    we_n = w;
    A    = a;
    DI   = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 5'h00, 8'h00);
  endtask

  initial begin
    //             cs    we_n  a      di     pi        do     oe    po        pdir
    vecs[0]  = '{1'b0, 1'b1, 5'h00, 8'h00, 16'h0000, 8'h00, 1'b0, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 5'h01, 8'hF0, 16'h0000, 8'h00, 1'b0, 16'h0000, 16'h00F0};
    vecs[2]  = '{1'b1, 1'b0, 5'h00, 8'hA5, 16'h0000, 8'h00, 1'b0, 16'h00A5, 16'h00F0};
    vecs[3]  = '{1'b1, 1'b1, 5'h00, 8'h00, 16'h003C, 8'hAC, 1'b1, 16'h00A5, 16'h00F0};
    vecs[4]  = '{1'b1, 1'b1, 5'h01, 8'h00, 16'h003C, 8'hF0, 1'b1, 16'h00A5, 16'h00F0};
    vecs[5]  = '{1'b1, 1'b0, 5'h06, 8'h55, 16'h003C, 8'h00, 1'b0, 16'h00A5, 16'h00F0};
    vecs[6]  = '{1'b1, 1'b1, 5'h06, 8'h00, 16'h003C, 8'h00, 1'b1, 16'h00A5, 16'h00F0};
    vecs[7]  = '{1'b1, 1'b0, 5'h03, 8'h0F, 16'h003C, 8'h00, 1'b0, 16'h00A5, 16'h0FF0};
    vecs[8]  = '{1'b1, 1'b0, 5'h02, 8'hC3, 16'h003C, 8'h00, 1'b0, 16'hC3A5, 16'h0FF0};
    vecs[9]  = '{1'b1, 1'b1, 5'h02, 8'h00, 16'h9900, 8'h93, 1'b1, 16'hC3A5, 16'h0FF0};
    vecs[10] = '{1'b0, 1'b1, 5'h00, 8'h00, 16'h9900, 8'h00, 1'b0, 16'hC3A5, 16'h0FF0};
    vecs[11] = '{1'b0, 1'b0, 5'h00, 8'hFF, 16'h9900, 8'h00, 1'b0, 16'hC3A5, 16'h0FF0};
    vecs[12] = '{1'b1, 1'b1, 5'h07, 8'h00, 16'h0000, 8'h00, 1'b1, 16'hC3A5, 16'h0FF0};
    vecs[13] = '{1'b1, 1'b1, 5'h00, 8'h00, 16'h0000, 8'hA0, 1'b1, 16'hC3A5, 16'h0FF0};

    // Reset block
    rst = 1'b1;
    PI  = 16'h0000;
    idle();
    #1;
    check("rst_po", PO, 16'h0000);
    check("rst_pdir", PDIR, 16'h0000);
    check("rst_irq", irq, 1'b0);
    check("rst_do", DO, 8'h00);
    check("rst_oe", OE, 1'b0);
    repeat (2) @(negedge phi2);
    rst = 1'b0;

    // Port vectors
    for (int i = 0; i < 14; i++) begin
      @(negedge phi2);
      drive(vecs[i].cs, vecs[i].we_n, vecs[i].a, vecs[i].di);
      PI = vecs[i].pi;
      #1;
      check($sformatf("vec%0d_do", i), DO, vecs[i].exp_do);
      check($sformatf("vec%0d_oe", i), OE, vecs[i].exp_oe);
      @(posedge phi2);
      #1;
      check($sformatf("vec%0d_po", i), PO, vecs[i].exp_po);
      check($sformatf("vec%0d_pdir", i), PDIR, vecs[i].exp_pdir);
    end
    @(negedge phi2);
    idle();

    // Div-8 countdown from 3 with tie=1
    @(negedge phi2);
    drive(1'b1, 1'b0, 5'h19, 8'h03);
    @(negedge phi2);
    for (int k = 0; k < 32; k++) begin
      drive(1'b1, 1'b1, 5'h19, 8'h00);
      #1;
      check($sformatf("div8_count_k%0d", k), DO, 8'(3 - k / 8));
      check($sformatf("div8_irq_k%0d", k), irq, 1'b0);
      @(negedge phi2);
    end
    drive(1'b1, 1'b1, 5'h14, 8'h00);
    #1;
    check("div8_status_uf", DO, 8'h80);
    check("div8_irq_uf", irq, 1'b1);
    @(negedge phi2);
    drive(1'b1, 1'b1, 5'h19, 8'h00);
    #1;
    check("div8_count_fe", DO, 8'hFE);
    check("div8_irq_before_clear", irq, 1'b1);
    @(negedge phi2);
    idle();
    #1;
    check("div8_irq_cleared", irq, 1'b0);
    drive(1'b1, 1'b1, 5'h14, 8'h00);
    #1;
    check("div8_status_cleared", DO, 8'h00);

    // Timer write in the exact underflow cycle wins
    @(negedge phi2);
    drive(1'b1, 1'b0, 5'h18, 8'h00);
    @(negedge phi2);
    drive(1'b1, 1'b0, 5'h1B, 8'h10);
    @(negedge phi2);
    drive(1'b1, 1'b1, 5'h14, 8'h00);
    #1;
    check("wr_uf_status", DO, 8'h00);
    check("wr_uf_irq", irq, 1'b0);
    @(negedge phi2);
    drive(1'b1, 1'b1, 5'h1B, 8'h00);
    #1;
    check("wr_uf_count", DO, 8'h10);
    check("wr_uf_irq2", irq, 1'b0);

    // Reset during a div-64 count with tflag set
    @(negedge phi2);
    drive(1'b1, 1'b0, 5'h1A, 8'h00);
    @(negedge phi2);
    idle();
    repeat (64) @(negedge phi2);
    #1;
    check("div64_irq_set", irq, 1'b1);
    rst = 1'b1;
    #1;
    check("async_rst_po", PO, 16'h0000);
    check("async_rst_pdir", PDIR, 16'h0000);
    check("async_rst_irq", irq, 1'b0);
    @(negedge phi2);
    rst = 1'b0;
    drive(1'b1, 1'b1, 5'h10, 8'h00);
    #1;
    check("post_rst_count", DO, 8'h00);
    drive(1'b1, 1'b1, 5'h14, 8'h00);
    for (int e = 1; e <= 1024; e++) begin
      @(negedge phi2);
      #1;
      if (e == 1023) check("post_rst_no_uf_1023", DO, 8'h00);
      if (e == 1024) check("post_rst_uf_1024", DO, 8'h80);
    end

    // Edge detection on PI[7]
    @(negedge phi2);
    drive(1'b1, 1'b0, 5'h13, 8'hFF);
    @(negedge phi2);
    drive(1'b1, 1'b0, 5'h17, 8'h00);
    @(negedge phi2);
    idle();
    PI = 16'h0000;
    @(negedge phi2);
    PI = 16'h0080;
    #1;
    check("edge_irq_pre", irq, 1'b0);
    @(negedge phi2);
    #1;
    check("edge_irq_rise", irq, EDGE_EN);
    drive(1'b1, 1'b1, 5'h14, 8'h00);
    #1;
    check("edge_status", DO, EDGE_EN ? 8'h40 : 8'h00);
    @(negedge phi2);
    idle();
    #1;
    check("edge_irq_cleared", irq, 1'b0);
    @(negedge phi2);
    PI = 16'h0000;
    @(negedge phi2);
    drive(1'b1, 1'b1, 5'h14, 8'h00);
    #1;
    check("edge_fall_status", DO, 8'h00);
    check("edge_fall_irq", irq, 1'b0);
    @(negedge phi2);
    idle();

    // Report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
